fifo_width_conv: RTL and testbench

//  Ready/valid FIFO that converts between input and output widths in either direction
//  (upsize, downsize or equal) for the AXI4 convertor datapaths.

---
 rtl/fifo_width_conv_if.sv | 26 ++
 rtl/fifo_width_conv.sv | 191 +++++++++++++++++++
 tb/tb_fifo_width_conv.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_width_conv_if.sv
// Ready/valid bundle for the width-converting FIFO: a write stream and a read stream.
interface fifo_width_conv_if #(
  parameter int DATA_WIDTH_IN  = 32,
  parameter int DATA_WIDTH_OUT = 128
);
  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_WIDTH_IN-1:0]  in_data;
  logic                      in_last;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_WIDTH_OUT-1:0] out_data;
  logic                      out_last;

  // Producer of write beats and consumer of read beats.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  // The FIFO itself.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/fifo_width_conv.sv
// Width-converting FWFT FIFO. Upsize packs narrow beats into wide entries through a
// staging register; downsize splits each wide entry into narrow beats on read.
// A LAST bit is stored per entry. Level flags decode the registered entry count.
module fifo_width_conv #(
  parameter int DATA_WIDTH_IN       = 32,
  parameter int DATA_WIDTH_OUT      = 128,
  parameter int MEM_DEPTH           = 16,
  parameter int NEARLY_FULL_THRESH  = 12,
  parameter int NEARLY_EMPTY_THRESH = 2,
  localparam int DEPTH = (MEM_DEPTH < 4) ? 4 : MEM_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           soft_clr,
  fifo_width_conv_if.slave io,
  output logic [AW:0]    fill_count,
  output logic           fifo_full,
  output logic           fifo_empty,
  output logic           fifo_nearly_full,
  output logic           fifo_nearly_empty,
  output logic           stage_busy
);

  localparam int  W         = (DATA_WIDTH_IN > DATA_WIDTH_OUT) ? DATA_WIDTH_IN : DATA_WIDTH_OUT;
  localparam bit  MODE_UP   = DATA_WIDTH_OUT > DATA_WIDTH_IN;
  localparam bit  MODE_DOWN = DATA_WIDTH_IN > DATA_WIDTH_OUT;

  logic                      in_fire;
  logic                      out_fire;
  logic                      commit;
  logic                      commit_last;
  logic [W-1:0]              commit_data;
  logic                      pop;
  logic [DATA_WIDTH_OUT-1:0] head_data;
  logic                      head_last;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic [W-1:0]  mem_q  [DEPTH];
  logic          last_q [DEPTH];

  // Level flags are pure decodes of the registered count; the staging entry is not counted.
  assign fill_count        = count_q;
  assign fifo_full         = (int'(count_q) == DEPTH);
  assign fifo_empty        = (count_q == '0);
  assign fifo_nearly_full  = (int'(count_q) >= NEARLY_FULL_THRESH);
  assign fifo_nearly_empty = (int'(count_q) <= NEARLY_EMPTY_THRESH);

  // in_ready looks only at the level, never at the read side, so no comb path out->in.
  assign io.in_ready  = !fifo_full && !rst;
  assign io.out_valid = !fifo_empty;
  assign io.out_data  = fifo_empty ? '0 : head_data;
  assign io.out_last  = !fifo_empty && head_last;

  // soft_clr wins over any handshake presented in the same cycle.
  assign in_fire  = io.in_valid  && io.in_ready  && !soft_clr;
  assign out_fire = io.out_valid && io.out_ready && !soft_clr;

  // ---------------------------------------------------------------- write side
  if (MODE_UP) begin : g_up
    localparam int RATIO = DATA_WIDTH_OUT / DATA_WIDTH_IN;
    localparam int LW    = $clog2(RATIO);

    logic [W-1:0]  stage_q, stage_d;
    logic [LW-1:0] wr_lane_q, wr_lane_d;

    // Merge the incoming beat into its lane and decide whether the entry closes.
    // NOTE: every always_comb target is given a default first, so no latch can be inferred.
    always_comb begin
      commit_data = stage_q;
      for (int l = 0; l < RATIO; l++) begin
        if (wr_lane_q == LW'(l)) commit_data[l*DATA_WIDTH_IN +: DATA_WIDTH_IN] = io.in_data;
      end
      commit      = in_fire && (io.in_last || (wr_lane_q == LW'(RATIO - 1)));
      commit_last = io.in_last;
      stage_d     = stage_q;
      wr_lane_d   = wr_lane_q;
      // Staging goes back to zero on commit so unwritten upper lanes read as zero next time.
      if (soft_clr || commit) begin
        stage_d   = '0;
        wr_lane_d = '0;
      end else if (in_fire) begin
        stage_d   = commit_data;
        wr_lane_d = wr_lane_q + 1'b1;
      end
    end

    // Staging register and lane counter.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stage_q   <= '0;
        wr_lane_q <= '0;
      end else begin
        stage_q   <= stage_d;
        wr_lane_q <= wr_lane_d;
      end
    end

    assign stage_busy = (wr_lane_q != '0);
  end else begin : g_direct
    // Each accepted beat is a whole entry.
    always_comb begin
      commit      = in_fire;
      commit_last = io.in_last;
      commit_data = io.in_data;
    end

    assign stage_busy = 1'b0;
  end

  // ----------------------------------------------------------------- read side
  if (MODE_DOWN) begin : g_down
    localparam int RATIO = DATA_WIDTH_IN / DATA_WIDTH_OUT;
    localparam int LW    = $clog2(RATIO);

    logic [LW-1:0] rd_lane_q, rd_lane_d;
    logic          lane_end;

    // Present lane rd_lane of the head entry; the entry pops after its final lane.
    always_comb begin
      head_data = '0;
      for (int l = 0; l < RATIO; l++) begin
        if (rd_lane_q == LW'(l)) head_data = mem_q[rd_ptr_q][l*DATA_WIDTH_OUT +: DATA_WIDTH_OUT];
      end
      lane_end  = (rd_lane_q == LW'(RATIO - 1));
      head_last = last_q[rd_ptr_q] && lane_end;
      pop       = out_fire && lane_end;
      rd_lane_d = rd_lane_q;
      if (soft_clr || pop) rd_lane_d = '0;
      else if (out_fire)   rd_lane_d = rd_lane_q + 1'b1;
    end

    // Read lane counter.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_lane_q <= '0;
      else     rd_lane_q <= rd_lane_d;
    end
  end else begin : g_whole
    // Whole entry per read beat.
    always_comb begin
      head_data = mem_q[rd_ptr_q];
      head_last = last_q[rd_ptr_q];
      pop       = out_fire;
    end
  end

  // ------------------------------------------------------- pointers and count
  // Pointers wrap naturally at the power-of-two depth; count is a true up/down counter.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (soft_clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (commit) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;
      if (commit && !pop)      count_d = count_q + 1'b1;
      else if (pop && !commit) count_d = count_q - 1'b1;
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, written only on commit.
  // NOTE: the array is deliberately not reset; out_* is masked while empty so stale words never show.
  always_ff @(posedge clk) begin
    if (commit) begin
      mem_q[wr_ptr_q]  <= commit_data;
      last_q[wr_ptr_q] <= commit_last;
    end
  end

endmodule

// File: tb/tb_fifo_width_conv.sv
// Self-checking bench: three instances (UP 32->128 depth 4, DOWN 128->32 depth 16,
// EQ 32->32 depth 4) checked against a queue-based reference model.
module tb_fifo_width_conv;

  localparam int NI = 3;
  localparam int DEPTH_K [NI] = '{4, 16, 4};
  localparam int NF_K    [NI] = '{3, 12, 3};
  localparam int NE_K    [NI] = '{1, 2, 1};

  logic clk = 1'b0;
  logic rst;
  logic soft_clr;
  always #5 clk = ~clk;

  logic         in_valid  [NI];
  logic         in_last   [NI];
  logic         out_ready [NI];
  logic [127:0] in_data   [NI];
  logic         in_ready  [NI];
  logic         out_valid [NI];
  logic         out_last  [NI];
  logic [127:0] out_data  [NI];
  logic [4:0]   fc        [NI];
  logic         full_f    [NI];
  logic         empty_f   [NI];
  logic         nfull_f   [NI];
  logic         nempty_f  [NI];
  logic         busy_f    [NI];

  logic [2:0] fc_up, fc_eq;
  logic [4:0] fc_dn;

  fifo_width_conv_if #(.DATA_WIDTH_IN(32),  .DATA_WIDTH_OUT(128)) up_if ();
  fifo_width_conv_if #(.DATA_WIDTH_IN(128), .DATA_WIDTH_OUT(32))  dn_if ();
  fifo_width_conv_if #(.DATA_WIDTH_IN(32),  .DATA_WIDTH_OUT(32))  eq_if ();

  fifo_width_conv #(.DATA_WIDTH_IN(32), .DATA_WIDTH_OUT(128), .MEM_DEPTH(4),
                    .NEARLY_FULL_THRESH(3), .NEARLY_EMPTY_THRESH(1)) u_up (
    .clk(clk), .rst(rst), .soft_clr(soft_clr), .io(up_if), .fill_count(fc_up),
    .fifo_full(full_f[0]), .fifo_empty(empty_f[0]), .fifo_nearly_full(nfull_f[0]),
    .fifo_nearly_empty(nempty_f[0]), .stage_busy(busy_f[0]));

  fifo_width_conv #(.DATA_WIDTH_IN(128), .DATA_WIDTH_OUT(32), .MEM_DEPTH(16),
                    .NEARLY_FULL_THRESH(12), .NEARLY_EMPTY_THRESH(2)) u_dn (
    .clk(clk), .rst(rst), .soft_clr(soft_clr), .io(dn_if), .fill_count(fc_dn),
    .fifo_full(full_f[1]), .fifo_empty(empty_f[1]), .fifo_nearly_full(nfull_f[1]),
    .fifo_nearly_empty(nempty_f[1]), .stage_busy(busy_f[1]));

  fifo_width_conv #(.DATA_WIDTH_IN(32), .DATA_WIDTH_OUT(32), .MEM_DEPTH(4),
                    .NEARLY_FULL_THRESH(3), .NEARLY_EMPTY_THRESH(1)) u_eq (
    .clk(clk), .rst(rst), .soft_clr(soft_clr), .io(eq_if), .fill_count(fc_eq),
    .fifo_full(full_f[2]), .fifo_empty(empty_f[2]), .fifo_nearly_full(nfull_f[2]),
    .fifo_nearly_empty(nempty_f[2]), .stage_busy(busy_f[2]));

  assign up_if.in_valid  = in_valid[0];
  assign up_if.in_data   = in_data[0][31:0];
  assign up_if.in_last   = in_last[0];
  assign up_if.out_ready = out_ready[0];
  assign in_ready[0]     = up_if.in_ready;
  assign out_valid[0]    = up_if.out_valid;
  assign out_data[0]     = up_if.out_data;
  assign out_last[0]     = up_if.out_last;
  assign fc[0]           = 5'(fc_up);

  assign dn_if.in_valid  = in_valid[1];
  assign dn_if.in_data   = in_data[1];
  assign dn_if.in_last   = in_last[1];
  assign dn_if.out_ready = out_ready[1];
  assign in_ready[1]     = dn_if.in_ready;
  assign out_valid[1]    = dn_if.out_valid;
  assign out_data[1]     = 128'(dn_if.out_data);
  assign out_last[1]     = dn_if.out_last;
  assign fc[1]           = fc_dn;

  assign eq_if.in_valid  = in_valid[2];
  assign eq_if.in_data   = in_data[2][31:0];
  assign eq_if.in_last   = in_last[2];
  assign eq_if.out_ready = out_ready[2];
  assign in_ready[2]     = eq_if.in_ready;
  assign out_valid[2]    = eq_if.out_valid;
  assign out_data[2]     = 128'(eq_if.out_data);
  assign out_last[2]     = eq_if.out_last;
  assign fc[2]           = 5'(fc_eq);

  int checks = 0;
  int errors = 0;

  // Reference model: expected output beats {last, data} per instance, plus UP partial beats.
  logic [128:0] exp_q [NI][$];
  logic [31:0]  pend [$];

  task automatic check(input string tag, input logic [128:0] obs, input logic [128:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entries currently held: DOWN entries carry 4 beats each, a partly read one still counts.
  function automatic int model_count(input int k);
    if (k == 1) return (exp_q[1].size() + 3) / 4;
    return exp_q[k].size();
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NI; k++) exp_q[k].delete();
    pend.delete();
  endtask

  task automatic model_in(input int k, input logic [127:0] d, input logic l);
    logic [127:0] e;
    case (k)
      0: begin
        pend.push_back(d[31:0]);
        if (l || pend.size() == 4) begin
          e = '0;
          for (int i = 0; i < pend.size(); i++) e = e | (128'(pend[i]) << (32 * i));
          exp_q[0].push_back({l, e});
          pend.delete();
        end
      end
      1: for (int i = 0; i < 4; i++) exp_q[1].push_back({l && (i == 3), 96'd0, d[32*i +: 32]});
      default: exp_q[2].push_back({l, 96'd0, d[31:0]});
    endcase
  endtask

  // One cycle: check levels at the negedge, score any handshakes, advance past the posedge.
  task automatic sample(input int k, output bit acc);
    int cnt;
    logic [128:0] e;
    @(negedge clk);
    cnt = model_count(k);
    acc = in_valid[k] && in_ready[k];
    check($sformatf("fill_count[%0d]", k), fc[k], cnt);
    check($sformatf("empty[%0d]", k), empty_f[k], cnt == 0);
    check($sformatf("full[%0d]", k), full_f[k], cnt == DEPTH_K[k]);
    check($sformatf("nearly_full[%0d]", k), nfull_f[k], cnt >= NF_K[k]);
    check($sformatf("nearly_empty[%0d]", k), nempty_f[k], cnt <= NE_K[k]);
    check($sformatf("out_valid[%0d]", k), out_valid[k], cnt != 0);
    check($sformatf("in_ready[%0d]", k), in_ready[k], cnt != DEPTH_K[k]);
    check($sformatf("stage_busy[%0d]", k), busy_f[k], (k == 0) && (pend.size() != 0));
    if (soft_clr) begin
      model_clear();
      acc = 1'b0;
    end else begin
      if (out_valid[k] && out_ready[k] && exp_q[k].size() != 0) begin
        e = exp_q[k].pop_front();
        check($sformatf("out_data[%0d]", k), out_data[k], e[127:0]);
        check($sformatf("out_last[%0d]", k), out_last[k], e[128]);
      end
      if (acc) model_in(k, in_data[k], in_last[k]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int k, input logic [127:0] d, input logic l);
    bit acc = 1'b0;
    in_valid[k] = 1'b1;
    in_data[k]  = d;
    in_last[k]  = l;
    for (int c = 0; c < 64 && !acc; c++) sample(k, acc);
    check($sformatf("send_accepted[%0d]", k), acc, 1'b1);
    in_valid[k] = 1'b0;
    in_last[k]  = 1'b0;
  endtask

  task automatic drain(input int k);
    bit acc;
    out_ready[k] = 1'b1;
    for (int c = 0; c < 400 && exp_q[k].size() != 0; c++) sample(k, acc);
    check($sformatf("drain_done[%0d]", k), exp_q[k].size() == 0, 1'b1);
    out_ready[k] = 1'b0;
    sample(k, acc);
  endtask

  task automatic check_reset(input int k);
    @(negedge clk);
    check($sformatf("rst_out_valid[%0d]", k), out_valid[k], 1'b0);
    check($sformatf("rst_out_last[%0d]", k), out_last[k], 1'b0);
    check($sformatf("rst_out_data[%0d]", k), out_data[k], 129'd0);
    check($sformatf("rst_fill_count[%0d]", k), fc[k], 129'd0);
    check($sformatf("rst_empty[%0d]", k), empty_f[k], 1'b1);
    check($sformatf("rst_full[%0d]", k), full_f[k], 1'b0);
    check($sformatf("rst_nearly_empty[%0d]", k), nempty_f[k], 1'b1);
    check($sformatf("rst_nearly_full[%0d]", k), nfull_f[k], 1'b0);
    check($sformatf("rst_stage_busy[%0d]", k), busy_f[k], 1'b0);
    check($sformatf("rst_in_ready[%0d]", k), in_ready[k], !rst);
  endtask

  task automatic random_run(input int k, input int n);
    int  sent = 0;
    int  c = 0;
    bit  acc;
    while ((sent < n || exp_q[k].size() != 0) && c < 3000) begin
      in_valid[k]  = (sent < n) && ($urandom_range(0, 1) == 1);
      in_data[k]   = {$urandom, $urandom, $urandom, $urandom};
      in_last[k]   = (sent == n - 1) || ($urandom_range(0, 3) == 0);
      out_ready[k] = ($urandom_range(0, 2) != 0);
      sample(k, acc);
      if (acc) sent++;
      c++;
    end
    check($sformatf("random_complete[%0d]", k), (sent == n) && (exp_q[k].size() == 0), 1'b1);
    in_valid[k]  = 1'b0;
    in_last[k]   = 1'b0;
    out_ready[k] = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    rst      = 1'b1;
    soft_clr = 1'b0;
    for (int k = 0; k < NI; k++) begin
      in_valid[k]  = 1'b0;
      in_last[k]   = 1'b0;
      out_ready[k] = 1'b0;
      in_data[k]   = '0;
    end

    // Reset state, while rst is high and after release.
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) check_reset(k);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < NI; k++) check_reset(k);
    @(posedge clk);
    #1;

    // UP: eight beats pack into two entries, read back in order.
    for (int i = 0; i < 8; i++) send(0, 128'(32'hA000_0000 + i), 1'b0);
    check("t1_fill_count", fc[0], 129'd2);
    check("t1_head", out_data[0], 128'hA000_0003_A000_0002_A000_0001_A000_0000);
    drain(0);

    // UP: short burst closed by in_last, upper lanes zero.
    send(0, 128'hB000_0000, 1'b0);
    check("t2_busy_after_b0", busy_f[0], 1'b1);
    send(0, 128'hB000_0001, 1'b1);
    check("t2_busy_after_commit", busy_f[0], 1'b0);
    check("t2_head", out_data[0], 128'h0000_0000_0000_0000_B000_0001_B000_0000);
    check("t2_last", out_last[0], 1'b1);
    drain(0);

    // DOWN: one LAST entry becomes four consecutive narrow beats.
    out_ready[1] = 1'b1;
    send(1, 128'hD000_0003_D000_0002_D000_0001_D000_0000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_valid_%0d", i), out_valid[1], 1'b1);
      check($sformatf("t3_data_%0d", i), out_data[1], 128'(32'hD000_0000 + i));
      check($sformatf("t3_last_%0d", i), out_last[1], i == 3);
      sample(1, acc);
    end
    check("t3_empty_after", empty_f[1], 1'b1);
    out_ready[1] = 1'b0;

    // EQ: fill to full, then concurrent push and pop keep the level steady.
    for (int i = 0; i < 4; i++) send(2, 128'(32'hE000_0000 + i), i[0]);
    check("t4_full", full_f[2], 1'b1);
    check("t4_in_ready", in_ready[2], 1'b0);
    check("t4_fill_count", fc[2], 129'd4);
    check("t4_nearly_full", nfull_f[2], 1'b1);
    in_valid[2]  = 1'b1;
    out_ready[2] = 1'b1;
    in_data[2]   = 128'hE000_0010;
    for (int i = 0; i < 6; i++) begin
      sample(2, acc);
      if (acc) in_data[2] = in_data[2] + 1;
    end
    check("t4_steady_count", fc[2], 129'd3);
    in_valid[2] = 1'b0;
    drain(2);

    // Random traffic with backpressure through every instance.
    random_run(2, 40);
    random_run(1, 40);
    random_run(0, 40);

    // soft_clr in the middle of an UP assembly drops the partial entry and the beat.
    send(0, 128'hC000_0000, 1'b0);
    send(0, 128'hC000_0001, 1'b0);
    check("t6_busy_before_clr", busy_f[0], 1'b1);
    in_valid[0] = 1'b1;
    in_data[0]  = 128'hC000_0002;
    soft_clr    = 1'b1;
    sample(0, acc);
    soft_clr    = 1'b0;
    in_valid[0] = 1'b0;
    check_reset(0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) send(0, 128'(32'hC100_0000 + i), i == 3);
    check("t6_repack", out_data[0], 128'hC100_0003_C100_0002_C100_0001_C100_0000);
    drain(0);

    // rst in the middle of bursts: partial UP staging and a partly read DOWN entry.
    send(0, 128'hF000_0000, 1'b0);
    send(0, 128'hF000_0001, 1'b0);
    send(1, 128'h9000_0003_9000_0002_9000_0001_9000_0000, 1'b0);
    out_ready[1] = 1'b1;
    sample(1, acc);
    sample(1, acc);
    rst = 1'b1;
    model_clear();
    out_ready[1] = 1'b0;
    for (int k = 0; k < NI; k++) check_reset(k);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < NI; k++) check_reset(k);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) send(0, 128'(32'hF100_0000 + i), i == 3);
    check("t6_rst_repack", out_data[0], 128'hF100_0003_F100_0002_F100_0001_F100_0000);
    drain(0);
    send(1, 128'h9100_0003_9100_0002_9100_0001_9100_0000, 1'b1);
    check("t6_rst_down_lane0", out_data[1], 128'h9100_0000);
    drain(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
